// File: rtl/dram_addr_mapper_if.sv
// ============================================================================
// Module   : dram_addr_mapper_if
// Purpose  : Request/result bus of the DRAM address mapper: an address
//            request channel, a table-clear strobe, and the decoded result
//            channel with row-hit and error flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dram_addr_mapper_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int BANK_W     = 3,
  parameter int ROW_W      = 7,
  parameter int COL_W      = 3
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  tbl_clr;
  logic                  out_valid;
  logic                  out_ready;
  logic [BANK_W-1:0]     out_bank;
  logic [ROW_W-1:0]      out_row;
  logic [COL_W-1:0]      out_col;
  logic                  out_row_hit;
  logic                  out_err;

  // Requester side: issues addresses and consumes mapped results
  modport master (
    output in_valid, in_addr, tbl_clr, out_ready,
    input  in_ready, out_valid, out_bank, out_row, out_col, out_row_hit, out_err
  );

  // Mapper side
  modport slave (
    input  in_valid, in_addr, tbl_clr, out_ready,
    output in_ready, out_valid, out_bank, out_row, out_col, out_row_hit, out_err
  );

endinterface

`default_nettype wire

// File: rtl/dram_addr_mapper.sv
// ============================================================================
// Module   : dram_addr_mapper
// Purpose  : Splits an L2 request address into DRAM bank/row/column fields
//            using one of three layouts (bank:row:col, row:bank:col, or
//            XOR-hashed bank:row:col), flags address bits beyond the mapped
//            range, and presents the result through a single registered
//            valid/ready output stage.
//            Optional macro DRAM_ADDR_MAPPER_HIT_TRACK_EN adds a per-bank
//            open-row table and drives out_row_hit; without it the hit flag
//            is constant zero and tbl_clr is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_addr_mapper #(
  parameter int ADDR_WIDTH   = 13,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int MAP_MODE     = 0
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  dram_addr_mapper_if.slave bus
);

  localparam int C_BW   = $clog2(NUM_OF_BANKS);
  localparam int C_RW   = $clog2(NUM_OF_ROWS);
  localparam int C_CW   = $clog2(NUM_OF_COLS);
  localparam int C_USED = C_BW + C_RW + C_CW;

  localparam bit C_BANKS_POW2 = (NUM_OF_BANKS > 0) && ((NUM_OF_BANKS & (NUM_OF_BANKS - 1)) == 0);
  localparam bit C_ROWS_POW2  = (NUM_OF_ROWS  > 0) && ((NUM_OF_ROWS  & (NUM_OF_ROWS  - 1)) == 0);
  localparam bit C_COLS_POW2  = (NUM_OF_COLS  > 0) && ((NUM_OF_COLS  & (NUM_OF_COLS  - 1)) == 0);

  // Refuse to build a mapper whose fields do not fit or do not tile exactly
  if (!C_BANKS_POW2 || !C_ROWS_POW2 || !C_COLS_POW2) begin : g_cfg_pow2_err
    $error("dram_addr_mapper: bank/row/column counts must be powers of two");
  end
  if (ADDR_WIDTH < C_USED) begin : g_cfg_width_err
    $error("dram_addr_mapper: ADDR_WIDTH smaller than bank+row+col width");
  end
  if (MAP_MODE < 0 || MAP_MODE > 2) begin : g_cfg_mode_err
    $error("dram_addr_mapper: MAP_MODE must be 0, 1 or 2");
  end

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [C_BW-1:0] w_bank;
  logic [C_RW-1:0] w_row;
  logic [C_CW-1:0] w_col;
  logic            w_err;
  logic            w_hit;
  logic            w_accept;

  assign w_col = bus.in_addr[C_CW-1:0];

  if (MAP_MODE == 1) begin : g_map_row_bank_col
    assign w_row  = bus.in_addr[C_USED-1 -: C_RW];
    assign w_bank = bus.in_addr[C_CW+C_BW-1 : C_CW];
  end else begin : g_map_bank_row_col
    logic [C_BW-1:0] w_bank_lin;
    assign w_row      = bus.in_addr[C_CW+C_RW-1 : C_CW];
    assign w_bank_lin = bus.in_addr[C_USED-1 -: C_BW];
    if (MAP_MODE == 2) begin : g_hash
      // Spreads consecutive rows of one linear bank across banks
      if (C_RW >= C_BW) begin : g_row_wide
        assign w_bank = w_bank_lin ^ w_row[C_BW-1:0];
      end else begin : g_row_narrow
        assign w_bank = w_bank_lin ^ C_BW'(w_row);
      end
    end else begin : g_linear
      assign w_bank = w_bank_lin;
    end
  end

  // Any set bit above the mapped range marks the request as out of range
  if (ADDR_WIDTH > C_USED) begin : g_err_chk
    assign w_err = |bus.in_addr[ADDR_WIDTH-1:C_USED];
  end else begin : g_err_none
    assign w_err = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic out_valid_q, out_valid_d;

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // --------------------------------------------------------------------------
  // Open-row table
  // --------------------------------------------------------------------------
`ifdef DRAM_ADDR_MAPPER_HIT_TRACK_EN
  logic [NUM_OF_BANKS-1:0] tbl_vld_q, tbl_vld_d;
  logic [C_RW-1:0]         tbl_row_q [NUM_OF_BANKS];

  // A clear in the same cycle wins over the stored entry, so the hit is forced low
  assign w_hit = !bus.tbl_clr && tbl_vld_q[w_bank] && (tbl_row_q[w_bank] == w_row);

  // Clear first, then mark the accepted bank open
  always_comb begin
    tbl_vld_d = bus.tbl_clr ? '0 : tbl_vld_q;
    if (w_accept) begin
      tbl_vld_d[w_bank] = 1'b1;
    end
  end

  // Table state: valid bits and the last row opened in each bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_vld_q <= '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) begin
        tbl_row_q[i] <= '0;
      end
    end else begin
      tbl_vld_q <= tbl_vld_d;
      if (w_accept) begin
        tbl_row_q[w_bank] <= w_row;
      end
    end
  end
`else
  logic w_unused_tbl_clr;

  assign w_unused_tbl_clr = bus.tbl_clr;
  assign w_hit            = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  logic [C_BW-1:0] out_bank_q, out_bank_d;
  logic [C_RW-1:0] out_row_q,  out_row_d;
  logic [C_CW-1:0] out_col_q,  out_col_d;
  logic            out_hit_q,  out_hit_d;
  logic            out_err_q,  out_err_d;

  // Load on accept, drop valid once consumed, otherwise hold everything
  always_comb begin
    out_valid_d = out_valid_q;
    out_bank_d  = out_bank_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_hit_d   = out_hit_q;
    out_err_d   = out_err_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      out_bank_d  = w_bank;
      out_row_d   = w_row;
      out_col_d   = w_col;
      out_hit_d   = w_hit;
      out_err_d   = w_err;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Result stage registers; reset discards any held result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_bank_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_hit_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_bank_q  <= out_bank_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_hit_q   <= out_hit_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_bank    = out_bank_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_col     = out_col_q;
  assign bus.out_row_hit = out_hit_q;
  assign bus.out_err     = out_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dram_addr_mapper.sv
// ============================================================================
// Module   : tb_dram_addr_mapper
// Purpose  : Self-checking bench for dram_addr_mapper. Four instances share
//            one stimulus stream: mode 0, mode 1, mode 2 (13-bit address) and
//            mode 0 with a 16-bit address. Expected results are pushed to a
//            scoreboard on accept and compared while each result is shown.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_addr_mapper;

  localparam int C_N = 4;

  typedef struct packed {
    logic [C_N-1:0][2:0] bank;
    logic [C_N-1:0][6:0] row;
    logic [C_N-1:0][2:0] col;
    logic [C_N-1:0]      hit;
    logic [C_N-1:0]      err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_addr;
  logic        tbl_clr;
  logic        out_ready;

  logic [C_N-1:0]      a_vld;
  logic [C_N-1:0]      a_rdy;
  logic [C_N-1:0]      a_hit;
  logic [C_N-1:0]      a_err;
  logic [C_N-1:0][2:0] a_bank;
  logic [C_N-1:0][6:0] a_row;
  logic [C_N-1:0][2:0] a_col;

  int n_tot;
  int n_bad;

  exp_t sb[$];
  logic m_valid;
  bit   m_tv [C_N][8];
  logic [6:0] m_tr [C_N][8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < C_N; k++) begin : g_dut
    localparam int AW   = (k == 3) ? 16 : 13;
    localparam int MODE = (k == 3) ? 0 : k;

    dram_addr_mapper_if #(.ADDR_WIDTH(AW), .BANK_W(3), .ROW_W(7), .COL_W(3)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.in_addr   = in_addr[AW-1:0];
    assign bus.tbl_clr   = tbl_clr;
    assign bus.out_ready = out_ready;

    assign a_vld[k]  = bus.out_valid;
    assign a_rdy[k]  = bus.in_ready;
    assign a_hit[k]  = bus.out_row_hit;
    assign a_err[k]  = bus.out_err;
    assign a_bank[k] = bus.out_bank;
    assign a_row[k]  = bus.out_row;
    assign a_col[k]  = bus.out_col;

    dram_addr_mapper #(
      .ADDR_WIDTH  (AW),
      .NUM_OF_BANKS(8),
      .NUM_OF_ROWS (128),
      .NUM_OF_COLS (8),
      .MAP_MODE    (MODE)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Arithmetic reference decode for 8 banks, 128 rows, 8 columns
  function automatic void model_map(input int mode, input int unsigned a,
                                    output logic [2:0] b, output logic [6:0] r,
                                    output logic [2:0] c);
    c = 3'(a % 8);
    if (mode == 1) begin
      b = 3'((a / 8) % 8);
      r = 7'((a / 64) % 128);
    end else begin
      r = 7'((a / 8) % 128);
      b = 3'((a / 1024) % 8);
      if (mode == 2) b = b ^ r[2:0];
    end
  endfunction

  task automatic clear_tables();
    for (int k = 0; k < C_N; k++)
      for (int i = 0; i < 8; i++) m_tv[k][i] = 1'b0;
  endtask

  // Reference model and scoreboard, evaluated mid-cycle
  initial begin
    exp_t e;
    logic rdy;
    logic acc;
    logic [2:0] b;
    logic [6:0] r;
    logic [2:0] c;
    int unsigned a;
    m_valid = 1'b0;
    clear_tables();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_valid = 1'b0;
        sb.delete();
        clear_tables();
        for (int k = 0; k < C_N; k++) begin
          check_eq($sformatf("rst_vld%0d", k),  32'(a_vld[k]),  32'd0);
          check_eq($sformatf("rst_bank%0d", k), 32'(a_bank[k]), 32'd0);
          check_eq($sformatf("rst_row%0d", k),  32'(a_row[k]),  32'd0);
          check_eq($sformatf("rst_col%0d", k),  32'(a_col[k]),  32'd0);
          check_eq($sformatf("rst_hit%0d", k),  32'(a_hit[k]),  32'd0);
          check_eq($sformatf("rst_err%0d", k),  32'(a_err[k]),  32'd0);
        end
      end else begin
        rdy = !m_valid || out_ready;
        for (int k = 0; k < C_N; k++) begin
          check_eq($sformatf("in_ready%0d", k),  32'(a_rdy[k]), 32'(rdy));
          check_eq($sformatf("out_valid%0d", k), 32'(a_vld[k]), 32'(m_valid));
        end
        if (m_valid) begin
          if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb[0];
            for (int k = 0; k < C_N; k++) begin
              check_eq($sformatf("bank%0d", k), 32'(a_bank[k]), 32'(e.bank[k]));
              check_eq($sformatf("row%0d", k),  32'(a_row[k]),  32'(e.row[k]));
              check_eq($sformatf("col%0d", k),  32'(a_col[k]),  32'(e.col[k]));
              check_eq($sformatf("hit%0d", k),  32'(a_hit[k]),  32'(e.hit[k]));
              check_eq($sformatf("err%0d", k),  32'(a_err[k]),  32'(e.err[k]));
            end
            if (out_ready) void'(sb.pop_front());
          end
        end
        acc = in_valid && rdy;
`ifdef DRAM_ADDR_MAPPER_HIT_TRACK_EN
        if (tbl_clr) clear_tables();
`endif
        if (acc) begin
          for (int k = 0; k < C_N; k++) begin
            a = (k == 3) ? 32'(in_addr) : 32'(in_addr[12:0]);
            model_map((k == 3) ? 0 : k, a, b, r, c);
            e.bank[k] = b;
            e.row[k]  = r;
            e.col[k]  = c;
            e.err[k]  = (k == 3) ? (in_addr[15:13] != 3'd0) : 1'b0;
`ifdef DRAM_ADDR_MAPPER_HIT_TRACK_EN
            e.hit[k]  = !tbl_clr && m_tv[k][b] && (m_tr[k][b] == r);
            m_tv[k][b] = 1'b1;
            m_tr[k][b] = r;
`else
            e.hit[k]  = 1'b0;
`endif
          end
          sb.push_back(e);
          m_valid = 1'b1;
        end else if (out_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [15:0] a, input logic c, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_addr   = a;
    tbl_clr   = c;
    out_ready = r;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tot     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    tbl_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reference addresses for each layout
    cyc(1, 16'h1C05, 0, 1);
    cyc(1, 16'h1C0D, 0, 1);
    cyc(0, 16'h0000, 0, 1);

    // Row-hit sequence, standalone clear, then clear together with accept
    cyc(1, 16'h0008, 0, 1);
    cyc(1, 16'h0009, 0, 1);
    cyc(1, 16'h0010, 0, 1);
    cyc(0, 16'h0000, 1, 1);
    cyc(1, 16'h0010, 0, 1);
    cyc(1, 16'h0011, 1, 1);
    cyc(1, 16'h0012, 0, 1);
    cyc(0, 16'h0000, 0, 1);

    // Downstream stall with a pending request, then full-rate drain
    cyc(1, 16'h0A21, 0, 0);
    cyc(1, 16'h0B32, 0, 0);
    cyc(1, 16'h0B32, 0, 0);
    cyc(1, 16'h0B32, 0, 0);
    cyc(1, 16'h0B32, 0, 1);
    cyc(1, 16'h1F47, 0, 1);
    cyc(1, 16'h0358, 0, 1);
    cyc(0, 16'h0000, 0, 1);

    // Random traffic including out-of-range upper bits
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
    end
    cyc(0, 16'h0000, 0, 1);
    cyc(0, 16'h0000, 0, 1);

    // Out-of-range request held, then reset while the result is pending
    cyc(1, 16'h2005, 0, 0);
    cyc(0, 16'h0000, 0, 0);
    cyc(0, 16'h0000, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < C_N; k++)
      check_eq($sformatf("async_rst_vld%0d", k), 32'(a_vld[k]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1, 16'h0123, 0, 1);
    cyc(1, 16'h0124, 0, 1);
    cyc(0, 16'h0000, 0, 1);
    cyc(0, 16'h0000, 0, 1);
    cyc(0, 16'h0000, 0, 1);
    @(posedge clk);
    #1;
    check_eq("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
